// File: rtl/bpred_btb_param.sv
// bpred_btb_param: parametrised branch target buffer plus pattern history
// table. IF looks up the fetch PC combinationally; ID allocates BTB entries
// and trains the saturating counters at the clock edge when not stalled.
// Optional feature macro: BPRED_GSHARE_EN. When defined, the PHT index is
// the BTB index XORed with a GHR_W-bit global history register.
module bpred_btb_param #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pre_taken,
    output logic [31:0] pre_bjpc,
    input  logic [31:0] ud_pc,
    input  logic        ud_BTB,
    input  logic        ud_pdt,
    input  logic        ud_taken,
    input  logic [31:0] real_bjpc,
    input  logic        pre_fch_wrong,
    input  logic        stall,
    output logic [31:0] mis_cnt
);

    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] ud_idx;
    logic [IDX_W-1:0] lk_pht;
    logic [IDX_W-1:0] ud_pht;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] ud_tag;
    logic             lk_hit;
    logic             ud_hit;
    logic [CTR_W-1:0] ud_ctr;
    logic [CTR_W-1:0] ctr_next;
    logic             upd_en;

    // The two low PC bits are always zero for aligned instructions.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ud_pc[1:0]};

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[31:IDX_W+2];
    assign ud_idx = ud_pc[IDX_W+1:2];
    assign ud_tag = ud_pc[31:IDX_W+2];
    assign upd_en = !stall;

`ifdef BPRED_GSHARE_EN
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] ghr_ext;

    assign ghr_ext = IDX_W'(ghr);
    assign lk_pht  = lk_idx ^ ghr_ext;
    assign ud_pht  = ud_idx ^ ghr_ext;

    // Global history shifts in the resolved direction on every trained branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (upd_en && ud_pdt) begin
            ghr <= GHR_W'({ghr, ud_taken});
        end
    end
`else
    logic [GHR_W-1:0] unused_ghr;
    assign unused_ghr = '0;
    assign lk_pht     = lk_idx;
    assign ud_pht     = ud_idx;
`endif

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign ud_hit = valid_q[ud_idx] && (tag_q[ud_idx] == ud_tag);
    assign ud_ctr = ctr_q[ud_pht];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        pre_taken = lk_hit && ctr_q[lk_pht][CTR_W-1];
        pre_bjpc  = if_pc + 32'd4;
        if (pre_taken) begin
            pre_bjpc = target_q[lk_idx];
        end
    end

    // Saturating step of the counter addressed by the update port.
    always_comb begin
        ctr_next = ud_ctr;
        if (ud_taken) begin
            if (ud_ctr != CTR_MAX) begin
                ctr_next = ud_ctr + 1'b1;
            end
        end else begin
            if (ud_ctr != '0) begin
                ctr_next = ud_ctr - 1'b1;
            end
        end
    end

    // BTB entries are (re)allocated on ud_BTB, overwriting any aliased tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (upd_en && ud_BTB) begin
            valid_q[ud_idx]  <= 1'b1;
            tag_q[ud_idx]    <= ud_tag;
            target_q[ud_idx] <= real_bjpc;
        end
    end

    // Counters: allocation seeds a weak state, training only touches hitting entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (upd_en) begin
            if (ud_BTB) begin
                ctr_q[ud_pht] <= ud_taken ? CTR_WT : CTR_WNT;
            end else if (ud_pdt && ud_hit) begin
                ctr_q[ud_pht] <= ctr_next;
            end
        end
    end

    // Mispredict event counter, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_cnt <= '0;
        end else if (upd_en && pre_fch_wrong) begin
            mis_cnt <= mis_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_bpred_btb_param.sv
// tb_bpred_btb_param: directed vectors for bpred_btb_param with a
// behavioural table model checked on every negative clock edge, plus
// hand-computed literal expectations. Honors BPRED_GSHARE_EN.
module tb_bpred_btb_param;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int CTR_W   = 2;
    localparam int GHR_W   = 4;
    localparam int HALF    = 1 << (CTR_W - 1);
    localparam int CMAX    = (1 << CTR_W) - 1;

    localparam logic        Y  = 1'b1;
    localparam logic        N  = 1'b0;
    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0040_0050;
    localparam logic [31:0] PC = 32'h0040_0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] if_pc;
    logic        pre_taken;
    logic [31:0] pre_bjpc;
    logic [31:0] ud_pc;
    logic        ud_BTB;
    logic        ud_pdt;
    logic        ud_taken;
    logic [31:0] real_bjpc;
    logic        pre_fch_wrong;
    logic        stall;
    logic [31:0] mis_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;
    logic mis_preload = 1'b0;

    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_mis;
`ifdef BPRED_GSHARE_EN
    int          m_ghr;
`endif

    bpred_btb_param #(
        .ENTRIES(ENTRIES),
        .IDX_W(IDX_W),
        .CTR_W(CTR_W),
        .GHR_W(GHR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_pc(if_pc),
        .pre_taken(pre_taken),
        .pre_bjpc(pre_bjpc),
        .ud_pc(ud_pc),
        .ud_BTB(ud_BTB),
        .ud_pdt(ud_pdt),
        .ud_taken(ud_taken),
        .real_bjpc(real_bjpc),
        .pre_fch_wrong(pre_fch_wrong),
        .stall(stall),
        .mis_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic int m_pht(input int i);
`ifdef BPRED_GSHARE_EN
        return i ^ m_ghr;
`else
        return i;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] lk, input logic [31:0] upc,
                                 input logic btb, input logic pdt, input logic tkn,
                                 input logic [31:0] tgt, input logic wrong, input logic st);
        @(posedge clk);
        #1;
        if_pc         = lk;
        ud_pc         = upc;
        ud_BTB        = btb;
        ud_pdt        = pdt;
        ud_taken      = tkn;
        real_bjpc     = tgt;
        pre_fch_wrong = wrong;
        stall         = st;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] lk);
        applyStimulus(lk, 32'h0, N, N, N, 32'h0, N, N);
    endtask

    // Reference model: table contents evolve by the predictor's rules.
    always @(posedge clk or negedge rst_n or posedge mis_preload) begin : model
        int  u_i;
        int  u_p;
        bit  u_hit;
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i]  = 0;
                m_tag[i]    = '0;
                m_target[i] = '0;
                m_ctr[i]    = HALF - 1;
            end
            m_mis = '0;
`ifdef BPRED_GSHARE_EN
            m_ghr = 0;
`endif
        end else if (mis_preload) begin
            m_mis = 32'hFFFF_FFFF;
        end else if (!stall) begin
            u_i   = m_idx(ud_pc);
            u_p   = m_pht(u_i);
            u_hit = m_valid[u_i] && (m_tag[u_i] == m_tagof(ud_pc));
            if (ud_BTB) begin
                m_valid[u_i]  = 1;
                m_tag[u_i]    = m_tagof(ud_pc);
                m_target[u_i] = real_bjpc;
                m_ctr[u_p]    = ud_taken ? HALF : HALF - 1;
            end else if (ud_pdt && u_hit) begin
                if (ud_taken) m_ctr[u_p] = (m_ctr[u_p] < CMAX) ? m_ctr[u_p] + 1 : CMAX;
                else          m_ctr[u_p] = (m_ctr[u_p] > 0) ? m_ctr[u_p] - 1 : 0;
            end
`ifdef BPRED_GSHARE_EN
            if (ud_pdt) m_ghr = (m_ghr * 2 + int'(ud_taken)) % (1 << GHR_W);
`endif
            if (pre_fch_wrong) m_mis = m_mis + 32'd1;
        end
    end

    // Every cycle, compare DUT outputs with the model's prediction.
    always @(negedge clk) begin : compare
        int          c_i;
        bit          c_tk;
        logic [31:0] c_pc;
        if (chk_en) begin
            c_i  = m_idx(if_pc);
            c_tk = m_valid[c_i] && (m_tag[c_i] == m_tagof(if_pc)) && (m_ctr[m_pht(c_i)] >= HALF);
            c_pc = c_tk ? m_target[c_i] : if_pc + 32'd4;
            checkOutput("model_pre_taken", 32'(pre_taken), 32'(c_tk));
            checkOutput("model_pre_bjpc", pre_bjpc, c_pc);
            checkOutput("model_mis_cnt", mis_cnt, m_mis);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        if_pc = PA; ud_pc = '0; ud_BTB = N; ud_pdt = N; ud_taken = N;
        real_bjpc = '0; pre_fch_wrong = N; stall = N;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_pre_taken", 32'(pre_taken), 32'd0);
        checkOutput("rst_pre_bjpc", pre_bjpc, 32'h0040_0014);
        checkOutput("rst_mis_cnt", mis_cnt, 32'd0);
        chk_en = 1;
        #9 rst_n = 1'b1;

        // Allocate taken with same-cycle lookup: old value now, new value next cycle.
        applyStimulus(PA, PA, Y, N, Y, 32'h0040_0100, N, N);
        checkOutput("alloc_same_taken", 32'(pre_taken), 32'd0);
        checkOutput("alloc_same_bjpc", pre_bjpc, 32'h0040_0014);
        idle(PA);
        checkOutput("alloc_taken", 32'(pre_taken), 32'd1);
        checkOutput("alloc_bjpc", pre_bjpc, 32'h0040_0100);

        // Stalled allocation and misfetch leave everything unchanged.
        applyStimulus(PA, PA, Y, N, N, 32'h0040_0200, Y, Y);
        idle(PA);
        checkOutput("stall_taken", 32'(pre_taken), 32'd1);
        checkOutput("stall_bjpc", pre_bjpc, 32'h0040_0100);
        checkOutput("stall_mis_cnt", mis_cnt, 32'd0);

        // Not-taken allocation hits but predicts fall-through.
        applyStimulus(PC, PC, Y, N, N, 32'h0040_0300, N, N);
        idle(PC);
        checkOutput("nt_alloc_taken", 32'(pre_taken), 32'd0);
        checkOutput("nt_alloc_bjpc", pre_bjpc, 32'h0040_0024);

        // Aliased tag overwrites the entry; the old PC now misses.
        applyStimulus(PA, PB, Y, N, Y, 32'h0040_0500, N, N);
        idle(PA);
        checkOutput("alias_old_taken", 32'(pre_taken), 32'd0);
        checkOutput("alias_old_bjpc", pre_bjpc, 32'h0040_0014);
        idle(PB);
        checkOutput("alias_new_bjpc", pre_bjpc, 32'h0040_0500);

        // Training a non-hitting PC does not touch the shared counter.
        applyStimulus(PB, PA, N, Y, N, 32'h0, N, N);
        applyStimulus(PB, PA, N, Y, N, 32'h0, N, N);
        idle(PB);
        checkOutput("nohit_train_taken", 32'(pre_taken), 32'd1);

        // Five misfetch pulses.
        for (int i = 0; i < 5; i++) applyStimulus(PB, 32'h0, N, N, N, 32'h0, Y, N);
        idle(PB);
        checkOutput("mis_cnt_five", mis_cnt, 32'd5);

        // Preload the counter to all ones and pulse once: it wraps to zero.
        #1;
        force dut.mis_cnt = 32'hFFFF_FFFF;
        mis_preload = 1'b1;
        #1;
        release dut.mis_cnt;
        mis_preload = 1'b0;
        pre_fch_wrong = Y;
        idle(PB);
        checkOutput("mis_cnt_wrap", mis_cnt, 32'd0);

        // Reset arriving during a pending allocation discards it.
        applyStimulus(PA, PA, Y, N, Y, 32'h0040_0700, N, N);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        ud_BTB = N; ud_taken = N; real_bjpc = '0;
        #2 rst_n = 1'b1;
        idle(PA);
        checkOutput("midrst_taken", 32'(pre_taken), 32'd0);
        checkOutput("midrst_bjpc", pre_bjpc, 32'h0040_0014);
        checkOutput("midrst_mis_cnt", mis_cnt, 32'd0);

`ifndef BPRED_GSHARE_EN
        // Counter saturation on a taken-allocated entry (counter starts at 2).
        applyStimulus(PA, PA, Y, N, Y, 32'h0040_0100, N, N);
        applyStimulus(PA, PA, N, Y, Y, 32'h0, N, N);
        applyStimulus(PA, PA, N, Y, Y, 32'h0, N, N);
        applyStimulus(PA, PA, N, Y, Y, 32'h0, N, N);
        applyStimulus(PA, PA, N, Y, N, 32'h0, N, N);
        checkOutput("sat_ctr3_taken", 32'(pre_taken), 32'd1);
        applyStimulus(PA, PA, N, Y, N, 32'h0, N, N);
        checkOutput("sat_ctr2_taken", 32'(pre_taken), 32'd1);
        applyStimulus(PA, PA, N, Y, N, 32'h0, N, N);
        checkOutput("sat_ctr1_taken", 32'(pre_taken), 32'd0);
        applyStimulus(PA, PA, N, Y, N, 32'h0, N, N);
        checkOutput("sat_ctr0_taken", 32'(pre_taken), 32'd0);
        applyStimulus(PA, PA, N, Y, Y, 32'h0, N, N);
        checkOutput("sat_floor_taken", 32'(pre_taken), 32'd0);
        applyStimulus(PA, PA, N, Y, Y, 32'h0, N, N);
        checkOutput("sat_up1_taken", 32'(pre_taken), 32'd0);
        idle(PA);
        checkOutput("sat_up2_taken", 32'(pre_taken), 32'd1);
        checkOutput("sat_up2_bjpc", pre_bjpc, 32'h0040_0100);
`else
        // Four taken trainings fill the history; PHT index for PA becomes 4'b1011.
        applyStimulus(PA, PA, Y, N, Y, 32'h0040_0100, N, N);
        for (int i = 0; i < 4; i++) applyStimulus(PA, PA, N, Y, Y, 32'h0, N, N);
        idle(PA);
        checkOutput("gshare_ghr", 32'(dut.ghr), 32'hF);
        checkOutput("gshare_cold_taken", 32'(pre_taken), 32'd0);
        checkOutput("gshare_cold_bjpc", pre_bjpc, 32'h0040_0014);
        applyStimulus(PA, PA, Y, N, Y, 32'h0040_0100, N, N);
        idle(PA);
        checkOutput("gshare_idx11_taken", 32'(pre_taken), 32'd1);
        checkOutput("gshare_idx11_bjpc", pre_bjpc, 32'h0040_0100);
        checkOutput("gshare_ghr_hold", 32'(dut.ghr), 32'hF);
`endif

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bpred_btb_param.md
Name: bpred_btb_param

Overview:
- Parametrised branch target buffer and pattern history table feeding the IF stage, updated from the ID stage of the interrupt/FPU pipeline.
- IF looks up the fetch PC and receives a predicted next PC and a taken flag.
- ID returns allocate and update requests plus the real branch/jump target.
- Generalises the fixed 2-bit predictor to configurable depth and counter width, adds a mispredict counter, and optionally adds gshare indexing.

Parameters:
- ENTRIES, 16, BTB and PHT depth; power of two, 4..256.
- IDX_W, 4, log2(ENTRIES); must be consistent with ENTRIES.
- CTR_W, 2, saturating counter width, 1..4.
- GHR_W, 4, global history length, at most IDX_W; used only with GSHARE_EN.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  fetch PC for lookup.
- pre_taken  out  1  predicted taken.
- pre_bjpc  out  32  predicted next PC.
- ud_pc  in  32  PC of the branch/jump now in ID (pcd).
- ud_BTB  in  1  allocate/overwrite the BTB entry for ud_pc.
- ud_pdt  in  1  train the counter for ud_pc.
- ud_taken  in  1  resolved direction of the ID instruction.
- real_bjpc  in  32  resolved target from ID.
- pre_fch_wrong  in  1  ID detected a misfetch this cycle.
- stall  in  1  ID stalled (wpcir low); suppresses every update.
- mis_cnt  out  32  mispredict event count.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
  - BTB entry = valid, tag, target[31:0].
  - PHT entry = CTR_W-bit counter.
- Lookup (combinational from registered state):
  - hit = valid[idx] && tag match.
  - pre_taken = hit && counter MSB.
  - pre_bjpc = pre_taken ? target : if_pc+4 (mod 2^32).
- Updates occur only at posedge clk with stall=0.
- ud_BTB:
  - valid=1, tag=ud tag, target=real_bjpc.
  - PHT counter initialised to 2^(CTR_W-1) if ud_taken, else 2^(CTR_W-1)-1.
- ud_pdt without ud_BTB, and the ud entry hits:
  - counter +1 if ud_taken, saturating at 2^CTR_W-1.
  - otherwise -1, saturating at 0.
  - ud_pdt on a non-hitting entry: counter unchanged.
- ud_BTB and ud_pdt in the same cycle: ud_BTB initialisation wins; no extra increment.
- Lookup and update on the same index in the same cycle: lookup returns pre-update state (no bypass); the new value is visible next cycle.
- Aliasing: a different tag at the same idx is a miss; ud_BTB overwrites it.
- mis_cnt:
  - +1 on each posedge with pre_fch_wrong=1 and stall=0.
  - wraps 0xFFFFFFFF -> 0.
- Reset (async assert, registers release on the next clk edge):
  - all valid=0.
  - all counters = 2^(CTR_W-1)-1 (weakly not taken).
  - targets and tags = 0.
  - mis_cnt=0, GHR=0.
  - So pre_taken=0 and pre_bjpc=if_pc+4 immediately.
- Reset asserted mid-update: the update is discarded.
- CTR_W=1: counter is a single taken bit; init and saturation rules apply as written.

Optional Feature:
- Macro: BPRED_GSHARE_EN.
- Defined:
  - GHR_W-bit global history register.
  - PHT index = idx XOR {0, GHR} for both lookup and update, using the current GHR before the shift.
  - BTB remains indexed by idx.
  - On each ud_pdt with stall=0: GHR <= {GHR[GHR_W-2:0], ud_taken}.
  - An ud_BTB without ud_pdt does not shift the GHR.
- Undefined:
  - No GHR register.
  - PHT indexed by idx alone.
  - GHR_W ignored.

Test Plan:
- Reset: release reset, if_pc=0x00400010 -> pre_taken=0, pre_bjpc=0x00400014, mis_cnt=0.
- Allocate: ud_pc=0x00400010, real_bjpc=0x00400100, ud_BTB=1, ud_taken=1 -> next cycle lookup of 0x00400010 gives pre_taken=1, pre_bjpc=0x00400100.
- Saturation (CTR_W=2):
  - 3 ud_pdt taken -> counter 3.
  - 2 not-taken -> pre_taken=0 only after the second.
  - further not-taken holds the counter at 0.
- Alias: allocate 0x00400010, then ud_BTB on 0x00400050 (same idx, ENTRIES=16) -> lookup 0x00400010 misses, pre_bjpc=0x00400014.
- Stall and simultaneity:
  - ud_BTB with stall=1 -> no change.
  - same-cycle lookup/update of one idx -> old value that cycle, new value next cycle.
- Counter and gshare:
  - 5 pre_fch_wrong pulses -> mis_cnt=5.
  - preload 0xFFFFFFFF via force, one pulse -> 0.
  - with BPRED_GSHARE_EN, ud_pdt taken x4 -> GHR=4'b1111, and PHT idx for 0x00400010 becomes 4'b0100 ^ 4'b1111 = 4'b1011.
